// File: rtl/cpu_pkg.sv
// Shared widths, register count and the enums used by the register-file write arbiter.
package cpu_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;
    localparam int NREG       = 1 << ADDR_W_DEF;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_e;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LD  = 1'b1
    } pri_state_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request channels from ALU and load unit, plus the register-file write port.
interface rf_write_arbiter_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                       hold;
    logic                       alu_valid;
    logic [ADDR_W-1:0]          alu_addr;
    logic [DATA_W-1:0]          alu_data;
    logic                       alu_ready;
    logic                       ld_valid;
    logic [ADDR_W-1:0]          ld_addr;
    logic [DATA_W-1:0]          ld_data;
    logic                       ld_ready;
    logic                       rf_we;
    logic [ADDR_W-1:0]          rf_wa;
    logic [DATA_W-1:0]          rf_wd;
    logic [(1<<ADDR_W)-1:0]     pend_mask;
    logic [7:0]                 conflict_cnt;

    modport master (
        output hold, alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        input  alu_ready, ld_ready, rf_we, rf_wa, rf_wd, pend_mask, conflict_cnt
    );

    modport slave (
        input  hold, alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        output alu_ready, ld_ready, rf_we, rf_wa, rf_wd, pend_mask, conflict_cnt
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ties go to the favoured side, and any grant hands
// the favour to the other requester.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_hold,
    output logic [1:0] o_gnt,
    output pri_state_e o_state
);
    pri_state_e r_state;
    pri_state_e w_state_nxt;
    logic [1:0] w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= PRI_ALU;
        else        r_state <= w_state_nxt;
    end

    // Grants are combinational from the requests so a lone requester never waits.
    always_comb begin
        w_gnt       = 2'b00;
        w_state_nxt = r_state;
        if (rst_n && !i_hold) begin
            if (i_req == 2'b11) begin
                if (r_state == PRI_ALU) w_gnt[REQ_ALU] = 1'b1;
                else                    w_gnt[REQ_LD]  = 1'b1;
            end else begin
                w_gnt = i_req;
            end
        end
        if (w_gnt[REQ_ALU])     w_state_nxt = PRI_LD;
        else if (w_gnt[REQ_LD]) w_state_nxt = PRI_ALU;
    end

    assign o_gnt   = w_gnt;
    assign o_state = r_state;
endmodule

// File: rtl/rf_write_arbiter.sv
// Merges ALU and load writebacks into one register-file write port, one write per
// cycle, with a pending-write mask and a saturating lost-arbitration counter.
module rf_write_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    rf_write_arbiter_if.slave   bus
);
    localparam int NR = 1 << ADDR_W;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    pri_state_e        w_unused_state;
    logic              w_lost;
    logic [NR-1:0]     w_pend;

    logic              r_we;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;
    logic [7:0]        r_cnt;

    assign w_req = {bus.ld_valid, bus.alu_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_req),
        .i_hold  (bus.hold),
        .o_gnt   (w_gnt),
        .o_state (w_unused_state)
    );

    assign bus.alu_ready = w_gnt[REQ_ALU];
    assign bus.ld_ready  = w_gnt[REQ_LD];

    // Hold cycles are a pipeline freeze, not a lost arbitration.
    assign w_lost = !bus.hold &&
                    ((bus.alu_valid && !w_gnt[REQ_ALU]) || (bus.ld_valid && !w_gnt[REQ_LD]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_wa  <= '0;
            r_wd  <= '0;
            r_cnt <= '0;
        end else begin
            r_we <= |w_gnt;
            if (w_gnt[REQ_LD]) begin
                r_wa <= bus.ld_addr;
                r_wd <= bus.ld_data;
            end else if (w_gnt[REQ_ALU]) begin
                r_wa <= bus.alu_addr;
                r_wd <= bus.alu_data;
            end
            if (w_lost && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_pend = '0;
        if (r_we) w_pend[r_wa] = 1'b1;
    end

    assign bus.rf_we        = r_we;
    assign bus.rf_wa        = r_wa;
    assign bus.rf_wd        = r_wd;
    assign bus.pend_mask    = w_pend;
    assign bus.conflict_cnt = r_cnt;
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width.
REQ-002 SHALL have parameter ADDR_W, default 2, register index width (NREG = 2**ADDR_W = 4).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port hold  input  1  freeze issue; no new grants while high.
REQ-006 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-007 SHALL have port alu_addr  input  ADDR_W  ALU destination register.
REQ-008 SHALL have port alu_data  input  DATA_W  ALU result.
REQ-009 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-010 SHALL have port ld_valid  input  1  load-unit writeback request.
REQ-011 SHALL have port ld_addr  input  ADDR_W  load destination register.
REQ-012 SHALL have port ld_data  input  DATA_W  load data.
REQ-013 SHALL have port ld_ready  output  1  load request accepted this cycle.
REQ-014 SHALL have port rf_we  output  1  register-file write enable.
REQ-015 SHALL have port rf_wa  output  ADDR_W  register-file write address.
REQ-016 SHALL have port rf_wd  output  DATA_W  register-file write data.
REQ-017 SHALL have port pend_mask  output  NREG  bit i high = write to register i issued, not yet committed.
REQ-018 SHALL have port conflict_cnt  output  8  saturating count of lost-arbitration cycles.

Function
REQ-019 SHALL transfer a request when valid and ready are both high on a rising edge; ready SHALL be combinational from valid, hold and priority state, and never depend on ready of the other side.
REQ-020 SHALL grant at most one requester per cycle; ready SHALL be 0 for both when hold=1.
REQ-021 SHALL use a 2-state priority FSM: PRI_ALU (ALU wins ties), PRI_LD (load wins ties); after any grant, state moves to favour the non-granted requester; no grant = state unchanged.
REQ-022 SHALL grant a lone valid requester regardless of FSM state.
REQ-023 SHALL register the granted addr/data: rf_we=1, rf_wa, rf_wd appear exactly one cycle after acceptance, for exactly one cycle; rf_we=0 in any cycle following no acceptance.
REQ-024 SHALL sustain one write per cycle with back-to-back grants (no bubbles while a request is valid and hold=0).
REQ-025 SHALL set pend_mask[rf_wa] exactly while rf_we=1; all other bits 0 (mask is one-hot or zero).
REQ-026 SHALL, when both valid to the same address, serialize them per REQ-021: the loser is written one cycle later, so its data is final in the register file.
REQ-027 SHALL increment conflict_cnt by 1 each cycle a requester is valid but not granted with hold=0; SHALL saturate at 255; hold cycles SHALL not count.
REQ-028 SHALL not require valid to stay asserted; a dropped unaccepted request is simply lost (no internal queue).

Reset
REQ-029 SHALL, on rst_n low, immediately clear rf_we, rf_wa, rf_wd, pend_mask, conflict_cnt to 0 and set FSM to PRI_ALU.
REQ-030 SHALL hold alu_ready and ld_ready at 0 while rst_n is low.
REQ-031 SHALL discard an accepted-but-uncommitted write when reset asserts mid-operation; no write SHALL occur on the first edge after reset release unless accepted on that edge.

Structure
REQ-032 SHALL place DATA_W/ADDR_W defaults, NREG and the requester-ID/priority-state enum in shared package cpu_pkg.
REQ-033 SHALL implement arbitration in one sub-module rr_arb2 (2-way round-robin: req[1:0], hold -> gnt[1:0], state); output register, pend_mask and counter stay in the top.

Verification
REQ-034 SHALL cover: reset, alu_valid=1 addr=2 data=0x5A -> alu_ready=1 same cycle; next cycle rf_we=1, rf_wa=2, rf_wd=0x5A, pend_mask=4'b0100.
REQ-035 SHALL cover: both valid every cycle for 4 cycles (ALU addr1, LD addr3) -> grants ALU, LD, ALU, LD; conflict_cnt=4.
REQ-036 SHALL cover: both valid addr=0, ALU 0x11, LD 0x22, from PRI_ALU -> rf writes 0x11 then 0x22; register 0 ends 0x22.
REQ-037 SHALL cover: hold=1 with both valid for 3 cycles -> readies 0, rf_we=0, conflict_cnt unchanged; hold=0 -> grant resumes per FSM.
REQ-038 SHALL cover: accept ALU write, assert rst_n low before next edge -> rf_we stays 0, pend_mask=0, FSM=PRI_ALU.
REQ-039 SHALL cover: 300 cycles of continuous contention -> conflict_cnt=255, no wrap.
